// File: rtl/dac_shift_controller.sv
// Automatic scaling controller for the DAC output corrector: tracks TX sample
// magnitude and drives the corrector's left-shift distance (fast attack, windowed release).
module dac_shift_controller #(
    parameter int unsigned WINDOW_LEN      = 4096,
    parameter int unsigned RELEASE_WINDOWS = 8,
    parameter int unsigned GUARD_BITS      = 1,
    parameter int unsigned INIT_DISTANCE   = 0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [27:0] DATA_IN,
    input  logic        data_valid,
    input  logic        tx_enable,
    input  logic [7:0]  max_distance,
    output logic [7:0]  distance,
    output logic        clip_event,
    output logic        update_strobe
);

    localparam int unsigned DATA_W = 28;
    localparam int unsigned MAG_W  = 27;
    localparam int unsigned HR_W   = 5;
    localparam int unsigned DIST_W = 8;
    localparam int unsigned WCNT_W = $clog2(WINDOW_LEN + 1);
    localparam int unsigned RCNT_W = $clog2(RELEASE_WINDOWS + 1);

    localparam logic [HR_W-1:0]   HR_MAX    = HR_W'(MAG_W);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_EVAL
    } state_e;

    // Leading-zero count of the 27-bit magnitude; zero maps to 27.
    function automatic logic [HR_W-1:0] headroom_f(input logic [MAG_W-1:0] m);
        logic [HR_W-1:0] h;
        h = HR_MAX;
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (m[i]) h = HR_W'(int'(MAG_W) - 1 - i);
        end
        return h;
    endfunction

    state_e              state_q, state_d;
    logic [MAG_W-1:0]    mag_c;
    logic [MAG_W-1:0]    mag1_q;
    logic                vld1_q, vld1_d;
    logic [HR_W-1:0]     hr1_c;
    logic                lt1_c;
    logic [HR_W-1:0]     hr2_q;
    logic [MAG_W-1:0]    mag2_q;
    logic                vld2_q;
    logic                lt2_q;
    logic [MAG_W-1:0]    peak_q, peak_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc_c;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d, rcnt_inc_c;
    logic [DIST_W-1:0]   distance_q, distance_d;
    logic                clip_q, clip_d;
    logic                strobe_q, strobe_d;
    logic                attack_c;
    logic [HR_W-1:0]     hr_peak_c;
    logic [DIST_W-1:0]   guarded_c;
    logic [DIST_W-1:0]   target_c;

    // Saturating magnitude: the most negative code folds onto the largest positive one.
    always_comb begin
        if (!DATA_IN[DATA_W-1]) begin
            mag_c = DATA_IN[MAG_W-1:0];
        end else if (DATA_IN[MAG_W-1:0] == '0) begin
            mag_c = '1;
        end else begin
            mag_c = MAG_W'(~DATA_IN[MAG_W-1:0] + MAG_W'(1));
        end
    end

    assign vld1_d = data_valid & tx_enable;
    assign hr1_c  = headroom_f(mag1_q);
    assign lt1_c  = DIST_W'(hr1_c) < distance_q;

    // Two-stage sample pipeline: magnitude, then headroom and compare.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mag1_q <= '0;
            vld1_q <= 1'b0;
            hr2_q  <= '0;
            mag2_q <= '0;
            vld2_q <= 1'b0;
            lt2_q  <= 1'b0;
        end else begin
            mag1_q <= mag_c;
            vld1_q <= vld1_d;
            hr2_q  <= hr1_c;
            mag2_q <= mag1_q;
            vld2_q <= vld1_q;
            lt2_q  <= lt1_c;
        end
    end

    // The registered compare is re-qualified against the live distance so a
    // sample queued behind an attack only fires if it is strictly lower still.
    assign attack_c = vld2_q && lt2_q && (DIST_W'(hr2_q) < distance_q) &&
                      ((state_q == ST_MEASURE) || (state_q == ST_EVAL));

    assign wcnt_inc_c = wcnt_q + WCNT_W'(1);
    assign rcnt_inc_c = rcnt_q + RCNT_W'(1);

    // Window target: peak headroom less guard, floored at 0 and capped at max_distance.
    always_comb begin
        hr_peak_c = headroom_f(peak_q);
        guarded_c = '0;
        if (32'(hr_peak_c) > GUARD_BITS) begin
            guarded_c = DIST_W'(32'(hr_peak_c) - GUARD_BITS);
        end
        target_c = (guarded_c < max_distance) ? guarded_c : max_distance;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            peak_q     <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            distance_q <= DIST_W'(INIT_DISTANCE);
            clip_q     <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            peak_q     <= peak_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            distance_q <= distance_d;
            clip_q     <= clip_d;
            strobe_q   <= strobe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        peak_d     = peak_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        distance_d = distance_q;
        clip_d     = 1'b0;
        strobe_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                peak_d = '0;
                wcnt_d = '0;
                rcnt_d = '0;
                if (tx_enable) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (vld2_q) begin
                    if (mag2_q > peak_q) peak_d = mag2_q;
                    wcnt_d = wcnt_inc_c;
                    if (wcnt_inc_c == WCNT_LAST) state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // A sample arriving during evaluation opens the next window.
                peak_d  = vld2_q ? mag2_q : '0;
                wcnt_d  = vld2_q ? WCNT_W'(1) : '0;
                state_d = ST_MEASURE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!tx_enable) state_d = ST_IDLE;

        // Distance update priority: fast attack, then max_distance clamp, then window release.
        if (attack_c) begin
            distance_d = DIST_W'(hr2_q);
            clip_d     = 1'b1;
            strobe_d   = 1'b1;
            rcnt_d     = '0;
        end else if (max_distance < distance_q) begin
            distance_d = max_distance;
            strobe_d   = 1'b1;
            rcnt_d     = '0;
        end else if (state_q == ST_EVAL) begin
            if (target_c < distance_q) begin
                distance_d = target_c;
                strobe_d   = 1'b1;
                rcnt_d     = '0;
            end else if (target_c == distance_q) begin
                rcnt_d = '0;
            end else if (32'(rcnt_inc_c) >= RELEASE_WINDOWS) begin
                distance_d = distance_q + DIST_W'(1);
                strobe_d   = 1'b1;
                rcnt_d     = '0;
            end else begin
                rcnt_d = rcnt_inc_c;
            end
        end
    end

    assign distance      = distance_q;
    assign clip_event    = clip_q;
    assign update_strobe = strobe_q;

endmodule

// File: tb/tb_dac_shift_controller.sv
// Directed bench for dac_shift_controller with a short window (16) and fast release (2).
module tb_dac_shift_controller;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [27:0] DATA_IN;
    logic        data_valid;
    logic        tx_enable;
    logic [7:0]  max_distance;
    logic [7:0]  distance;
    logic        clip_event;
    logic        update_strobe;

    int n_cmp = 0;
    int n_err = 0;

    dac_shift_controller #(
        .WINDOW_LEN      (16),
        .RELEASE_WINDOWS (2),
        .GUARD_BITS      (1),
        .INIT_DISTANCE   (0)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .DATA_IN       (DATA_IN),
        .data_valid    (data_valid),
        .tx_enable     (tx_enable),
        .max_distance  (max_distance),
        .distance      (distance),
        .clip_event    (clip_event),
        .update_strobe (update_strobe)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int n_strobe, n_clip, bad_step, first_strobe, prev, strobe_at16, max_seen;
        bit reached;

        reset_in     = 1'b1;
        tx_enable    = 1'b0;
        data_valid   = 1'b0;
        DATA_IN      = '0;
        max_distance = 8'd27;
        repeat (3) tick();
        check_eq("reset_distance", 32'(distance), 0);
        check_eq("reset_clip", 32'(clip_event), 0);
        check_eq("reset_strobe", 32'(update_strobe), 0);
        reset_in = 1'b0;

        // Release ramp with constant 1000: target 16, one step per two windows.
        tx_enable  = 1'b1;
        data_valid = 1'b1;
        DATA_IN    = 28'd1000;
        n_strobe = 0; n_clip = 0; bad_step = 0; first_strobe = -1; prev = 0; strobe_at16 = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (update_strobe) begin
                n_strobe++;
                if (first_strobe < 0) first_strobe = i;
                if (prev == 16) strobe_at16++;
                if (int'(distance) != prev + 1) bad_step++;
            end else if (int'(distance) != prev) begin
                bad_step++;
            end
            if (clip_event) n_clip++;
            prev = int'(distance);
        end
        check_eq("ramp_final_distance", 32'(distance), 16);
        check_eq("ramp_strobe_count", 32'(n_strobe), 16);
        check_eq("ramp_bad_steps", 32'(bad_step), 0);
        check_eq("ramp_clip_count", 32'(n_clip), 0);
        check_eq("ramp_no_strobe_at_16", 32'(strobe_at16), 0);
        check_eq("ramp_first_strobe_late", 32'(first_strobe >= 32), 1);

        // Fresh window, then a single 2^20 sample: attack to headroom 6.
        tx_enable = 1'b0;
        repeat (4) tick();
        check_eq("idle_hold_16", 32'(distance), 16);
        tx_enable = 1'b1;
        repeat (4) tick();
        DATA_IN = 28'd1 << 20;
        tick();
        DATA_IN = 28'd1000;
        tick();
        check_eq("attack_not_yet", 32'(distance), 16);
        check_eq("attack_not_yet_clip", 32'(clip_event), 0);
        tick();
        check_eq("attack_distance", 32'(distance), 6);
        check_eq("attack_clip", 32'(clip_event), 1);
        check_eq("attack_strobe", 32'(update_strobe), 1);
        tick();
        check_eq("attack_clip_one_cycle", 32'(clip_event), 0);
        check_eq("attack_strobe_one_cycle", 32'(update_strobe), 0);
        check_eq("attack_hold", 32'(distance), 6);

        // Clamp from 6 to 4 via max_distance, no clip.
        tick();
        max_distance = 8'd4;
        tick();
        check_eq("clamp_distance", 32'(distance), 4);
        check_eq("clamp_strobe", 32'(update_strobe), 1);
        check_eq("clamp_no_clip", 32'(clip_event), 0);
        n_strobe = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (update_strobe) n_strobe++;
        end
        check_eq("clamp_eval_no_strobe", 32'(n_strobe), 0);
        check_eq("clamp_eval_distance", 32'(distance), 4);
        n_strobe = 0; max_seen = 0;
        for (int i = 0; i < 85; i++) begin
            tick();
            if (update_strobe) n_strobe++;
            if (int'(distance) > max_seen) max_seen = int'(distance);
        end
        check_eq("clamp_windows_strobes", 32'(n_strobe), 0);
        check_eq("clamp_windows_max", 32'(max_seen), 4);

        // Release to 5, then abandon a window part way through.
        max_distance = 8'd27;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            tick();
            if (distance == 8'd5) reached = 1'b1;
        end
        check_eq("release_to_5_reached", 32'(reached), 1);
        tx_enable = 1'b0;
        repeat (3) tick();
        check_eq("idle_hold_5", 32'(distance), 5);
        tx_enable = 1'b1;
        repeat (12) tick();
        tx_enable = 1'b0;
        n_strobe = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (update_strobe) n_strobe++;
        end
        check_eq("abandon_no_strobe", 32'(n_strobe), 0);
        check_eq("abandon_hold_5", 32'(distance), 5);
        // Headroom of 2^21 is 5: no attack at 5, but the window target is 4.
        DATA_IN   = 28'd1 << 21;
        tx_enable = 1'b1;
        n_strobe = 0; bad_step = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (update_strobe) n_strobe++;
            if (distance != 8'd5) bad_step++;
        end
        check_eq("fresh_window_no_early_strobe", 32'(n_strobe), 0);
        check_eq("fresh_window_no_early_change", 32'(bad_step), 0);
        tick();
        check_eq("fresh_window_eval_distance", 32'(distance), 4);
        check_eq("fresh_window_eval_strobe", 32'(update_strobe), 1);
        check_eq("fresh_window_eval_no_clip", 32'(clip_event), 0);

        // Release to 10, then the most negative sample saturates to headroom 0.
        DATA_IN = 28'd1000;
        reached = 1'b0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            tick();
            if (distance == 8'd10) reached = 1'b1;
        end
        check_eq("release_to_10_reached", 32'(reached), 1);
        DATA_IN = 28'h8000000;
        tick();
        DATA_IN = 28'd1000;
        tick();
        check_eq("neg_full_not_yet", 32'(distance), 10);
        tick();
        check_eq("neg_full_distance", 32'(distance), 0);
        check_eq("neg_full_clip", 32'(clip_event), 1);
        check_eq("neg_full_strobe", 32'(update_strobe), 1);
        tick();
        check_eq("neg_full_clip_one_cycle", 32'(clip_event), 0);

        // Asynchronous reset mid-stream from a nonzero distance.
        reached = 1'b0;
        for (int i = 0; i < 150 && !reached; i++) begin
            tick();
            if (distance == 8'd1) reached = 1'b1;
        end
        check_eq("release_to_1_reached", 32'(reached), 1);
        #2;
        reset_in = 1'b1;
        #1;
        check_eq("async_reset_distance", 32'(distance), 0);
        check_eq("async_reset_clip", 32'(clip_event), 0);
        check_eq("async_reset_strobe", 32'(update_strobe), 0);
        tick();
        reset_in = 1'b0;
        n_strobe = 0; n_clip = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (update_strobe) n_strobe++;
            if (clip_event) n_clip++;
        end
        check_eq("post_reset_no_strobe", 32'(n_strobe), 0);
        check_eq("post_reset_no_clip", 32'(n_clip), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
